// File: rtl/z_result_buffer.sv
// Two-entry result FIFO between the ALU units and the datapath bus logic.
// Optional per-entry zero/neg flags are stored when Z_FLAGS_EN is defined.
module z_result_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              in_clk,
  input  logic              in_clr_n,
  input  logic              in_valid,
  output logic              out_ready,
  input  logic [DATA_W-1:0] in_lo,
  input  logic [DATA_W-1:0] in_hi,
  input  logic              in_wide,
  output logic              out_valid,
  input  logic              in_ready,
  output logic [DATA_W-1:0] out_zlo,
  output logic [DATA_W-1:0] out_zhi,
  output logic [1:0]        out_count,
  input  logic              in_flush,
  output logic              out_zero,
  output logic              out_neg
);

  logic [DATA_W-1:0] lo_q [2];
  logic [DATA_W-1:0] hi_q [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count_q;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] hi_in;

  assign out_ready = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_count = count_q;
  assign push      = in_valid & out_ready;
  assign pop       = out_valid & in_ready;
  assign hi_in     = in_wide ? in_hi : '0;

  always_ff @(posedge in_clk) begin
    if (!in_clr_n) begin
      count_q <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      lo_q[0] <= '0;
      lo_q[1] <= '0;
      hi_q[0] <= '0;
      hi_q[1] <= '0;
    end else if (in_flush) begin
      count_q <= 2'd0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
    end else begin
      if (push) begin
        lo_q[wr_ptr] <= in_lo;
        hi_q[wr_ptr] <= hi_in;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    out_zlo = '0;
    out_zhi = '0;
    if (out_valid) begin
      out_zlo = lo_q[rd_ptr];
      out_zhi = hi_q[rd_ptr];
    end
  end

`ifdef Z_FLAGS_EN
  logic zf_q [2];
  logic nf_q [2];
  logic zf_in;
  logic nf_in;

  // hi_in is already zero for narrow results, so one compare covers both cases
  assign zf_in = (in_lo == '0) & (hi_in == '0);
  assign nf_in = in_wide ? in_hi[DATA_W-1] : in_lo[DATA_W-1];

  always_ff @(posedge in_clk) begin
    if (!in_clr_n) begin
      zf_q[0] <= 1'b0;
      zf_q[1] <= 1'b0;
      nf_q[0] <= 1'b0;
      nf_q[1] <= 1'b0;
    end else if (!in_flush && push) begin
      zf_q[wr_ptr] <= zf_in;
      nf_q[wr_ptr] <= nf_in;
    end
  end

  always_comb begin
    out_zero = 1'b0;
    out_neg  = 1'b0;
    if (out_valid) begin
      out_zero = zf_q[rd_ptr];
      out_neg  = nf_q[rd_ptr];
    end
  end
`else
  assign out_zero = 1'b0;
  assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_z_result_buffer.sv
// Bench for z_result_buffer: directed steps then random traffic
// against a queue-based reference model.
module tb_z_result_buffer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         v_in;
  logic         rdy_out;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         wide;
  logic         v_out;
  logic         rdy_in;
  logic [W-1:0] zlo;
  logic [W-1:0] zhi;
  logic [1:0]   cnt;
  logic         flush;
  logic         zero;
  logic         neg;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         wide;
  } ent_t;

  ent_t q[$];

  z_result_buffer #(.DATA_W(W)) dut (
    .in_clk    (clk),
    .in_clr_n  (clr_n),
    .in_valid  (v_in),
    .out_ready (rdy_out),
    .in_lo     (lo),
    .in_hi     (hi),
    .in_wide   (wide),
    .out_valid (v_out),
    .in_ready  (rdy_in),
    .out_zlo   (zlo),
    .out_zhi   (zhi),
    .out_count (cnt),
    .in_flush  (flush),
    .out_zero  (zero),
    .out_neg   (neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic m_zero(input ent_t e);
`ifdef Z_FLAGS_EN
    return (e.lo == 0) && (e.hi == 0 || !e.wide);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_neg(input ent_t e);
`ifdef Z_FLAGS_EN
    return e.wide ? e.hi[W-1] : e.lo[W-1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all();
    ent_t h;
    chk("valid", W'(v_out), W'(q.size() != 0));
    chk("ready", W'(rdy_out), W'(q.size() < 2));
    chk("count", W'(cnt), W'(q.size()));
    if (q.size() != 0) begin
      h = q[0];
      chk("zlo", zlo, h.lo);
      chk("zhi", zhi, h.wide ? h.hi : '0);
      chk("zero", W'(zero), W'(m_zero(h)));
      chk("neg", W'(neg), W'(m_neg(h)));
    end else begin
      chk("zlo_empty", zlo, '0);
      chk("zhi_empty", zhi, '0);
      chk("zero_empty", W'(zero), '0);
      chk("neg_empty", W'(neg), '0);
    end
  endtask

  // Apply the current inputs to the model, clock once, then compare.
  task automatic tick();
    ent_t e;
    bit   do_pop;
    bit   do_push;
    if (!clr_n || flush) begin
      q.delete();
    end else begin
      do_pop  = (q.size() != 0) && rdy_in;
      do_push = v_in && (q.size() < 2);
      e.lo = lo;
      e.hi = hi;
      e.wide = wide;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic offer(input logic [W-1:0] l, input logic [W-1:0] h,
                       input logic w);
    v_in = 1'b1;
    lo   = l;
    hi   = h;
    wide = w;
  endtask

  initial begin
    clr_n  = 1'b0;
    v_in   = 1'b1;
    lo     = 32'h1234_5678;
    hi     = 32'h1;
    wide   = 1'b1;
    rdy_in = 1'b0;
    flush  = 1'b0;
    #2;

    // reset with in_valid high
    tick();
    chk("rst_valid", W'(v_out), '0);
    chk("rst_ready", W'(rdy_out), 1);
    chk("rst_count", W'(cnt), '0);
    chk("rst_zlo", zlo, '0);
    clr_n = 1'b1;

    // single narrow push, hi discarded, latency 1
    rdy_in = 1'b1;
    offer(32'h8000_0001, 32'hDEAD_BEEF, 1'b0);
    tick();
    v_in = 1'b0;
    chk("t2_valid", W'(v_out), 1);
    chk("t2_zlo", zlo, 32'h8000_0001);
    chk("t2_zhi", zhi, '0);
    tick();
    chk("t2_gone", W'(v_out), '0);

    // A, B, C with downstream stalled
    rdy_in = 1'b0;
    offer(32'd1, 32'd0, 1'b0);
    tick();
    offer(32'd2, 32'd0, 1'b0);
    tick();
    offer(32'd3, 32'd0, 1'b0);
    tick();
    chk("t3_full_ready", W'(rdy_out), '0);
    chk("t3_full_count", W'(cnt), 2);
    chk("t3_head_a", zlo, 32'd1);
    rdy_in = 1'b1;
    tick();
    chk("t3_head_b", zlo, 32'd2);
    tick();
    v_in = 1'b0;
    chk("t3_head_c", zlo, 32'd3);
    tick();
    chk("t3_drained", W'(cnt), '0);

    // count 1, simultaneous push and pop
    rdy_in = 1'b0;
    offer(32'hA, 32'd0, 1'b0);
    tick();
    rdy_in = 1'b1;
    offer(32'hB, 32'd0, 1'b0);
    tick();
    v_in = 1'b0;
    rdy_in = 1'b0;
    chk("t4_count", W'(cnt), 1);
    chk("t4_head", zlo, 32'hB);

    // fill then flush with a push offered
    offer(32'hC, 32'd0, 1'b0);
    tick();
    chk("t5_full", W'(cnt), 2);
    offer(32'hFACE, 32'd0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    v_in = 1'b0;
    chk("t5_count", W'(cnt), '0);
    chk("t5_valid", W'(v_out), '0);
    tick();
    chk("t5_absent", W'(cnt), '0);

    // flags
    offer(32'd0, 32'h5555_0000, 1'b0);
    tick();
    v_in = 1'b0;
`ifdef Z_FLAGS_EN
    chk("t6_zero_a", W'(zero), 1);
`else
    chk("t6_zero_a", W'(zero), 0);
`endif
    chk("t6_neg_a", W'(neg), 0);
    rdy_in = 1'b1;
    tick();
    offer(32'd0, 32'hFFFF_FFFF, 1'b1);
    rdy_in = 1'b0;
    tick();
    v_in = 1'b0;
    chk("t6_zero_b", W'(zero), 0);
`ifdef Z_FLAGS_EN
    chk("t6_neg_b", W'(neg), 1);
`else
    chk("t6_neg_b", W'(neg), 0);
`endif
    chk("t6_zhi_b", zhi, 32'hFFFF_FFFF);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      v_in   = ($urandom_range(9) < 7);
      rdy_in = $urandom_range(1);
      wide   = $urandom_range(1);
      lo     = ($urandom_range(5) == 0) ? '0 : W'($urandom);
      case ($urandom_range(3))
        0:       hi = '0;
        1:       hi = '1;
        default: hi = W'($urandom);
      endcase
      flush = ($urandom_range(29) == 0);
      clr_n = ($urandom_range(59) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
